// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the FIFO drain / byte packer.
package fifo_drain_pkg;

  localparam int unsigned OE_LEN_DEF   = 4;
  localparam int unsigned GAP_LEN_DEF  = 3;
  localparam int unsigned TOUT_LEN_DEF = 255;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned LANES   = 4;
  localparam int unsigned WORD_W  = BYTE_W * LANES;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned TOTAL_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2,
    EMIT = 2'd3
  } state_e;

  // Output word payload: packed bytes plus valid-byte count.
  typedef struct packed {
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] dat;
  } word_t;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_drain.sv
// Drains a byte FIFO with a timed read strobe and packs bytes into
// little-endian 32-bit words. Optional empty-FIFO flush timeout is
// enabled by defining FIFO_DRAIN_TOUT_EN.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned OE_LEN   = OE_LEN_DEF,
  parameter int unsigned GAP_LEN  = GAP_LEN_DEF,
  parameter int unsigned TOUT_LEN = TOUT_LEN_DEF
) (
  input  logic                clk,
  input  logic                sys_rst_n,
  input  logic                en,
  input  logic                flush,
  input  logic                fifo_empty,
  input  logic [BYTE_W-1:0]   fifo_dat,
  output logic                fifo_oe,
  output logic [WORD_W-1:0]   word_dat,
  output logic [CNT_W-1:0]    word_cnt,
  output logic                word_vld,
  input  logic                word_rdy,
  output logic [TOTAL_W-1:0]  byte_total,
  output logic                busy
);

  localparam int unsigned TMR_MAX = (OE_LEN > GAP_LEN) ? OE_LEN : GAP_LEN;
  localparam int unsigned TMR_W   = cnt_w(TMR_MAX);

  // Zero-length phases are meaningless; reject them at elaboration.
  if (OE_LEN == 0 || GAP_LEN == 0 || TOUT_LEN == 0) begin : g_param_chk
    $error("fifo_drain: OE_LEN, GAP_LEN and TOUT_LEN must be nonzero");
  end

  state_e               state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [WORD_W-1:0]    pack_q, pack_d;
  logic [CNT_W-1:0]     pack_cnt_q, pack_cnt_d;
  logic [TOTAL_W-1:0]   total_q, total_d;
  logic                 flush_pend_q, flush_pend_d;
  logic                 fifo_oe_q, fifo_oe_d;
  word_t                word_q, word_d;
  logic                 word_vld_q, word_vld_d;
  logic                 busy_q, busy_d;
  logic                 tout_hit_c;

`ifdef FIFO_DRAIN_TOUT_EN
  localparam int unsigned TOUT_W = cnt_w(TOUT_LEN);
  logic [TOUT_W-1:0] tout_q, tout_d;

  assign tout_hit_c = (state_q == IDLE) && fifo_empty && (pack_cnt_q != '0) &&
                      (tout_q == TOUT_W'(TOUT_LEN - 1));

  // Count idle cycles spent waiting on an empty FIFO with a partial word held.
  always_comb begin
    tout_d = tout_q;
    if (state_d == POP || state_d == EMIT) begin
      tout_d = '0;
    end else if (state_q == IDLE && fifo_empty && pack_cnt_q != '0) begin
      tout_d = tout_q + TOUT_W'(1);
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) tout_q <= '0;
    else            tout_q <= tout_d;
  end
`else
  assign tout_hit_c = 1'b0;
`endif

  // Next-state, pack register and registered-output computation.
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    pack_d       = pack_q;
    pack_cnt_d   = pack_cnt_q;
    total_d      = total_q;
    flush_pend_d = flush_pend_q;

    case (state_q)
      IDLE: begin
        // A pending flush is either serviced here or dropped (nothing held).
        flush_pend_d = 1'b0;
        tmr_d        = '0;
        if ((pack_cnt_q != '0) && (flush_pend_q || flush || tout_hit_c)) begin
          state_d = EMIT;
        end else if (en && !fifo_empty && (pack_cnt_q != CNT_W'(LANES))) begin
          state_d = POP;
        end
      end
      POP: begin
        if (flush) flush_pend_d = 1'b1;
        if (tmr_q == TMR_W'(OE_LEN - 1)) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            if (pack_cnt_q == CNT_W'(i)) pack_d[i*BYTE_W +: BYTE_W] = fifo_dat;
          end
          pack_cnt_d = pack_cnt_q + CNT_W'(1);
          total_d    = total_q + TOTAL_W'(1);
          tmr_d      = '0;
          state_d    = GAP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      GAP: begin
        if (flush) flush_pend_d = 1'b1;
        if (tmr_q == TMR_W'(GAP_LEN - 1)) begin
          tmr_d   = '0;
          state_d = (pack_cnt_q == CNT_W'(LANES)) ? EMIT : IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      EMIT: begin
        if (word_rdy) begin
          pack_d     = '0;
          pack_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    fifo_oe_d  = (state_d == POP);
    word_vld_d = (state_d == EMIT);
    word_d     = (state_d == EMIT) ? word_t'{cnt: pack_cnt_d, dat: pack_d} : '0;
    busy_d     = (state_d != IDLE) || (pack_cnt_d != '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      pack_q       <= '0;
      pack_cnt_q   <= '0;
      total_q      <= '0;
      flush_pend_q <= 1'b0;
      fifo_oe_q    <= 1'b0;
      word_q       <= '0;
      word_vld_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      pack_q       <= pack_d;
      pack_cnt_q   <= pack_cnt_d;
      total_q      <= total_d;
      flush_pend_q <= flush_pend_d;
      fifo_oe_q    <= fifo_oe_d;
      word_q       <= word_d;
      word_vld_q   <= word_vld_d;
      busy_q       <= busy_d;
    end
  end

  assign fifo_oe    = fifo_oe_q;
  assign word_dat   = word_q.dat;
  assign word_cnt   = word_q.cnt;
  assign word_vld   = word_vld_q;
  assign byte_total = total_q;
  assign busy       = busy_q;

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 The block SHALL have parameter OE_LEN, default 4, giving the FIFO read-strobe width in clk cycles.
REQ-002 The block SHALL have parameter GAP_LEN, default 3, giving the idle clk cycles after each strobe before empty is re-sampled.
REQ-003 The block SHALL have parameter TOUT_LEN, default 255, giving the clk cycles of FIFO-empty before a partial word is flushed.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-005 The block SHALL have port sys_rst_n, input, 1, reset; reset is asynchronous and active-low.
REQ-006 The block SHALL have port en, input, 1, drain enable.
REQ-007 The block SHALL have port flush, input, 1, a one-cycle request to emit any partial word.
REQ-008 The block SHALL have port fifo_empty, input, 1, the mos-to-arm FIFO empty flag (1 = empty).
REQ-009 The block SHALL have port fifo_dat, input, 8, the registered FIFO read data.
REQ-010 The block SHALL have port fifo_oe, output, 1, the FIFO read strobe; the FIFO read pointer advances after its falling edge.
REQ-011 The block SHALL have port word_dat, output, 32, the packed word, little-endian with the first byte in [7:0].
REQ-012 The block SHALL have port word_cnt, output, 3, the number of valid bytes in word_dat (1..4).
REQ-013 The block SHALL have port word_vld, output, 1, a valid flag for word_dat and word_cnt.
REQ-014 The block SHALL have port word_rdy, input, 1, the consumer ready flag.
REQ-015 The block SHALL have port byte_total, output, 16, the count of bytes popped since reset; it wraps.
REQ-016 The block SHALL have port busy, output, 1, high whenever state != IDLE or a partial word is held.

Function
REQ-017 The FSM SHALL have states IDLE, POP, GAP and EMIT.
REQ-018 From IDLE, with en=1, fifo_empty=0 and the pack register not full, the FSM SHALL go to POP.
REQ-019 In POP, fifo_oe SHALL be 1 for exactly OE_LEN cycles; on the last POP cycle fifo_dat SHALL be written into byte lane pack_cnt, pack_cnt SHALL be incremented and byte_total SHALL be incremented; the FSM then SHALL go to GAP.
REQ-020 In GAP, fifo_oe SHALL be 0 for GAP_LEN cycles; the FSM then SHALL go to EMIT if pack_cnt==4, else to IDLE.
REQ-021 EMIT SHALL also be entered from IDLE when pack_cnt>0 and either flush was seen or the timeout expired.
REQ-022 In EMIT, word_vld SHALL be 1, with word_cnt=pack_cnt and unused lanes of word_dat = 0.
REQ-023 A transfer SHALL occur on a cycle with word_vld & word_rdy; the word SHALL then be cleared, pack_cnt set to 0 and the FSM returned to IDLE.
REQ-024 word_dat and word_cnt SHALL stay stable while word_vld=1 and word_rdy=0.
REQ-025 No POP SHALL start while word_vld=1 (backpressure); the FIFO simply fills.
REQ-026 A flush arriving in POP or GAP SHALL be latched and serviced when the FSM next reaches IDLE.
REQ-027 A flush with pack_cnt==0 SHALL be discarded and SHALL emit nothing.
REQ-028 Clearing en SHALL let the current POP/GAP/EMIT complete and SHALL block only new POPs; flush SHALL still be honoured.
REQ-029 byte_total SHALL wrap 16'hFFFF -> 16'h0000 without any flag.
REQ-030 A minimum of OE_LEN+GAP_LEN cycles SHALL separate the rising edges of consecutive fifo_oe pulses.

Reset
REQ-031 On sys_rst_n=0, the block SHALL immediately drive fifo_oe=0, word_vld=0, word_dat=0, word_cnt=0, byte_total=0, busy=0 and pack_cnt=0, clear any latched flush, clear the timeout counter and enter IDLE.
REQ-032 A reset asserted during POP SHALL discard the byte being popped; loss of that byte is the defined behaviour.

Configuration
REQ-033 With FIFO_DRAIN_TOUT_EN defined, a counter SHALL count IDLE cycles with fifo_empty=1 and pack_cnt>0; reaching TOUT_LEN SHALL act as flush; the counter SHALL clear on any POP or EMIT.
REQ-034 With FIFO_DRAIN_TOUT_EN undefined, the counter SHALL be absent, and partial words SHALL leave the block only via flush.

Structure
REQ-035 The state enum and the default values of OE_LEN, GAP_LEN and TOUT_LEN SHALL be placed in the shared defs package.
REQ-036 The design SHALL be a single module with no sub-module; the pack register and lane counter SHALL be implemented inline.

Verification
REQ-037 The bench SHALL push 8 bytes 01..08 with word_rdy=1, and SHALL check two words 32'h04030201 and 32'h08070605, each with cnt=4, and byte_total=8.
REQ-038 The bench SHALL push 3 bytes AA, BB, CC, then pulse flush, and SHALL check one word 32'h00CCBBAA with cnt=3.
REQ-039 The bench SHALL hold word_rdy=0 after 4 bytes with 4 more queued, and SHALL check that fifo_oe stays 0 and word_dat stays stable; after word_rdy=1, the remaining 4 bytes SHALL drain.
REQ-040 With FIFO_DRAIN_TOUT_EN defined, the bench SHALL push 1 byte 5A and then leave the FIFO empty, and SHALL check word_vld rising exactly TOUT_LEN idle cycles later with cnt=1; with the macro undefined, the bench SHALL check that no word appears.
REQ-041 The bench SHALL assert reset on the 2nd cycle of POP, and SHALL check fifo_oe=0 asynchronously and all outputs at their reset values.
REQ-042 The bench SHALL preset byte_total to 16'hFFFF via 65535 pops, pop 1 more byte, and SHALL check byte_total=0.
